// File: rtl/instruction_fetch_mem.sv
// Instruction memory with a byte-wise loader FSM (IDLE/LOAD/RUN) and a registered fetch port.
// Optional debug readback port enabled by defining IMEM_READBACK_EN.
module instruction_fetch_mem #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 32,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [NB_ADDR-1:0]           i_pcounter,
  input  logic                         i_halt,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic                         i_load_start,
  input  logic                         i_load_valid,
  input  logic [7:0]                   i_load_byte,
`ifdef IMEM_READBACK_EN
  input  logic [$clog2(MEM_DEPTH)-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]           o_dbg_word,
`endif
  output logic [NB_DATA-1:0]           o_instruction,
  output logic [NB_ADDR-1:0]           o_pcounter4,
  output logic                         o_valid,
  output logic                         o_addr_fault,
  output logic                         o_loading,
  output logic                         o_load_done,
  output logic                         o_load_full
);

  localparam int                 AW          = $clog2(MEM_DEPTH);
  localparam logic [NB_ADDR-1:0] FETCH_LIMIT = NB_ADDR'(MEM_DEPTH * 4);
  localparam logic [AW-1:0]      LAST_WORD   = AW'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [AW-1:0]      wptr_r;
  logic [1:0]         byte_cnt_r;
  logic [NB_DATA-1:0] word_buf_r;
  logic [NB_DATA-1:0] mem_r [MEM_DEPTH];

  logic [NB_DATA-1:0] assembled_word_s;
  logic               mem_we_s;
  logic               fetch_fault_s;
  logic [AW-1:0]      fetch_idx_s;

  // Loader word assembly, write strobe and fetch address decode
  always_comb begin
    assembled_word_s = word_buf_r;
    assembled_word_s[8*byte_cnt_r +: 8] = i_load_byte;
    if (!i_rst && (state_r == ST_LOAD) && !i_load_start && i_load_valid && (byte_cnt_r == 2'd3)) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
    fetch_idx_s   = i_pcounter[AW+1:2];
    fetch_fault_s = (i_pcounter[1:0] != 2'b00) || (i_pcounter >= FETCH_LIMIT);
  end

  // Instruction storage: written only by the loader, never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wptr_r] <= assembled_word_s;
    end
  end

  // Load/run sequencing and registered fetch outputs
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      wptr_r        <= '0;
      byte_cnt_r    <= 2'd0;
      word_buf_r    <= '0;
      o_instruction <= '0;
      o_pcounter4   <= '0;
      o_valid       <= 1'b0;
      o_addr_fault  <= 1'b0;
      o_loading     <= 1'b0;
      o_load_done   <= 1'b0;
      o_load_full   <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_load_start) begin
            state_r    <= ST_LOAD;
            o_loading  <= 1'b1;
            wptr_r     <= '0;
            byte_cnt_r <= 2'd0;
            word_buf_r <= '0;
          end
        end
        ST_LOAD: begin
          if (i_load_start) begin
            wptr_r     <= '0;
            byte_cnt_r <= 2'd0;
            word_buf_r <= '0;
          end else if (i_load_valid) begin
            if (byte_cnt_r == 2'd3) begin
              byte_cnt_r <= 2'd0;
              word_buf_r <= '0;
              wptr_r     <= wptr_r + AW'(1);
              // HALT_WORD wins even when it lands in the last slot
              if (assembled_word_s == HALT_WORD) begin
                state_r     <= ST_RUN;
                o_loading   <= 1'b0;
                o_load_done <= 1'b1;
                o_load_full <= 1'b0;
              end else if (wptr_r == LAST_WORD) begin
                state_r     <= ST_RUN;
                o_loading   <= 1'b0;
                o_load_done <= 1'b1;
                o_load_full <= 1'b1;
              end
            end else begin
              word_buf_r <= assembled_word_s;
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (i_load_start) begin
            state_r    <= ST_LOAD;
            o_loading  <= 1'b1;
            o_valid    <= 1'b0;
            wptr_r     <= '0;
            byte_cnt_r <= 2'd0;
            word_buf_r <= '0;
          end else if (i_flush) begin
            o_instruction <= '0;
            o_pcounter4   <= i_pcounter + NB_ADDR'(4);
            o_valid       <= 1'b0;
            o_addr_fault  <= 1'b0;
          end else if (i_halt || i_stall) begin
            o_valid <= o_valid;
          end else if (fetch_fault_s) begin
            o_instruction <= '0;
            o_pcounter4   <= i_pcounter + NB_ADDR'(4);
            o_valid       <= 1'b0;
            o_addr_fault  <= 1'b1;
          end else begin
            o_instruction <= mem_r[fetch_idx_s];
            o_pcounter4   <= i_pcounter + NB_ADDR'(4);
            o_valid       <= 1'b1;
            o_addr_fault  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          o_loading <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_READBACK_EN
  // Debug readback of any word, independent of FSM state
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_dbg_word <= '0;
    end else begin
      o_dbg_word <= mem_r[i_dbg_addr];
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Self-checking bench for instruction_fetch_mem: loader sequences plus a table of fetch vectors
// whose expectations flow through a scoreboard queue.
module tb_instruction_fetch_mem;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_pcounter;
  logic        i_halt, i_stall, i_flush;
  logic        i_load_start, i_load_valid;
  logic [7:0]  i_load_byte;
  logic [31:0] o_instruction;
  logic [31:0] o_pcounter4;
  logic        o_valid, o_addr_fault, o_loading, o_load_done, o_load_full;

  instruction_fetch_mem dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_pcounter    (i_pcounter),
    .i_halt        (i_halt),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_load_start  (i_load_start),
    .i_load_valid  (i_load_valid),
    .i_load_byte   (i_load_byte),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_valid       (o_valid),
    .o_addr_fault  (o_addr_fault),
    .o_loading     (o_loading),
    .o_load_done   (o_load_done),
    .o_load_full   (o_load_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        halt;
    logic        flush;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[12];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    step();
    i_load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
  endtask

  task automatic send_halt();
    for (int k = 0; k < 3; k++) send_byte(8'hFF);
    send_byte(8'hFF);
  endtask

  // Drive one vector, queue its expectation, advance one edge, pop and compare
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    i_pcounter = v.pc;
    i_stall    = v.stall;
    i_halt     = v.halt;
    i_flush    = v.flush;
    e.instr = v.e_instr;
    e.pc4   = v.e_pc4;
    e.valid = v.e_valid;
    e.fault = v.e_fault;
    sb_q.push_back(e);
    step();
    i_stall = 1'b0;
    i_halt  = 1'b0;
    i_flush = 1'b0;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " instr"}, o_instruction, e.instr);
      chk({tag, " pc4"},   o_pcounter4,   e.pc4);
      chk({tag, " valid"}, {31'd0, o_valid},      {31'd0, e.valid});
      chk({tag, " fault"}, {31'd0, o_addr_fault}, {31'd0, e.fault});
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input string tag);
    vec_t v;
    v = '{pc, 1'b0, 1'b0, 1'b0, ei, pc + 32'd4, 1'b1, 1'b0};
    apply(v, tag);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [31:0] w;

    i_rst = 1'b1; i_pcounter = 32'd0; i_halt = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_load_start = 1'b0; i_load_valid = 1'b0; i_load_byte = 8'd0;
    step(); step();
    i_rst = 1'b0;
    chk("rst instr",   o_instruction, 32'd0);
    chk("rst pc4",     o_pcounter4,   32'd0);
    chk("rst valid",   {31'd0, o_valid},     32'd0);
    chk("rst loading", {31'd0, o_loading},   32'd0);
    chk("rst full",    {31'd0, o_load_full}, 32'd0);

    // IDLE ignores fetches and stray loader bytes
    i_pcounter = 32'd0;
    send_byte(8'h55);
    chk("idle valid",   {31'd0, o_valid},   32'd0);
    chk("idle loading", {31'd0, o_loading}, 32'd0);

    // First program: one instruction then HALT_WORD
    pulse_start();
    chk("load loading", {31'd0, o_loading}, 32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h08); send_byte(8'h20);
    chk("mid-load done", {31'd0, o_load_done}, 32'd0);
    send_halt();
    chk("halt done",    {31'd0, o_load_done}, 32'd1);
    chk("halt full",    {31'd0, o_load_full}, 32'd0);
    chk("halt loading", {31'd0, o_loading},   32'd0);
    i_pcounter = 32'd0;
    step();
    chk("done pulse width", {31'd0, o_load_done}, 32'd0);

    //           pc            stall halt  flush exp_instr      exp_pc4        v     f
    tbl[0]  = '{32'd0,         1'b0, 1'b0, 1'b0, 32'h20080013, 32'd4,        1'b1, 1'b0};
    tbl[1]  = '{32'd4,         1'b1, 1'b0, 1'b0, 32'h20080013, 32'd4,        1'b1, 1'b0};
    tbl[2]  = '{32'd4,         1'b0, 1'b1, 1'b0, 32'h20080013, 32'd4,        1'b1, 1'b0};
    tbl[3]  = '{32'd4,         1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd8,        1'b1, 1'b0};
    tbl[4]  = '{32'd0,         1'b0, 1'b0, 1'b1, 32'h0,        32'd4,        1'b0, 1'b0};
    tbl[5]  = '{32'd2,         1'b0, 1'b0, 1'b0, 32'h0,        32'd6,        1'b0, 1'b1};
    tbl[6]  = '{32'd0,         1'b1, 1'b0, 1'b0, 32'h0,        32'd6,        1'b0, 1'b1};
    tbl[7]  = '{32'd1024,      1'b0, 1'b0, 1'b0, 32'h0,        32'd1028,     1'b0, 1'b1};
    tbl[8]  = '{32'd1023,      1'b0, 1'b0, 1'b0, 32'h0,        32'd1027,     1'b0, 1'b1};
    tbl[9]  = '{32'hFFFFFFFC,  1'b0, 1'b0, 1'b0, 32'h0,        32'd0,        1'b0, 1'b1};
    tbl[10] = '{32'd4,         1'b1, 1'b0, 1'b1, 32'h0,        32'd8,        1'b0, 1'b0};
    tbl[11] = '{32'd0,         1'b0, 1'b0, 1'b0, 32'h20080013, 32'd4,        1'b1, 1'b0};
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reload from RUN with no HALT_WORD: memory fills, extra bytes are dropped
    pulse_start();
    chk("reload valid",   {31'd0, o_valid},   32'd0);
    chk("reload loading", {31'd0, o_loading}, 32'd1);
    done_cnt = 0;
    done_at  = -1;
    for (int wi = 0; wi < 256; wi++) begin
      w = 32'h1000_0000 + 32'(wi);
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        if (o_load_done) begin
          done_cnt++;
          done_at = wi * 4 + b;
        end
      end
    end
    chk("full done count", 32'(done_cnt), 32'd1);
    chk("full done byte",  32'(done_at),  32'd1023);
    chk("full flag",       {31'd0, o_load_full}, 32'd1);
    for (int k = 0; k < 4; k++) send_byte(8'h77);
    chk("extra loading", {31'd0, o_loading},   32'd0);
    chk("extra full",    {31'd0, o_load_full}, 32'd1);
    fetch(32'd0,    32'h1000_0000, "full w0");
    fetch(32'd512,  32'h1000_0080, "full w128");
    fetch(32'd1020, 32'h1000_00FF, "full w255");

    // Restart inside LOAD discards the partial word and the same-cycle byte
    pulse_start();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    i_load_valid = 1'b1; i_load_byte = 8'hEE; i_load_start = 1'b1;
    step();
    i_load_valid = 1'b0; i_load_start = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_halt();
    chk("restart full", {31'd0, o_load_full}, 32'd0);
    fetch(32'd0, 32'h04030201, "restart w0");
    fetch(32'd4, 32'hFFFFFFFF, "restart w1");

    // Reset mid-load loses the partial word
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("midrst loading", {31'd0, o_loading}, 32'd0);
    chk("midrst valid",   {31'd0, o_valid},   32'd0);
    chk("midrst pc4",     o_pcounter4,        32'd0);
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_halt();
    chk("midrst done", {31'd0, o_load_done}, 32'd1);
    fetch(32'd0, 32'hDDCCBBAA, "midrst w0");
    fetch(32'd4, 32'hFFFFFFFF, "midrst w1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
